// File: rtl/less_than_pkg.sv
// Shared alu constants and flag types for the signed less-than comparator.
package less_than_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int WIDTH_MIN     = 2;
    localparam int WIDTH_MAX     = 64;

    typedef struct packed {
        logic n;
        logic v;
        logic z;
    } flags_t;

    // Signed a < b from the flags of a - b; the wrapped sign alone is wrong on overflow.
    function automatic logic signed_lt(input flags_t f);
        return f.n ^ f.v;
    endfunction

endpackage

// File: rtl/less_than_sub_flags.sv
// Ripple-carry subtractor (a + ~b + 1) built from full-adder cells, with N/V/Z flags.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

module sub_flags
    import less_than_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             n,
    output logic             v,
    output logic             z
);
    logic [WIDTH:0] carry;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        fa_cell u_fa (
            .x  (a[i]),
            .y  (~b[i]),
            .ci (carry[i]),
            .s  (diff[i]),
            .co (carry[i+1])
        );
    end

    // Overflow when carry into and out of the sign bit disagree.
    assign n = diff[WIDTH-1];
    assign v = carry[WIDTH] ^ carry[WIDTH-1];
    assign z = ~|diff;

endmodule

// File: rtl/less_than.sv
// Signed comparator: combinational a < b on eq (historical name) plus a registered result path.
module less_than
    import less_than_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             eq,
    output logic             lt_q,
    output logic             same_q,
    output logic             out_valid
);
    flags_t           flags;
    logic [WIDTH-1:0] diff;
    logic             unused_diff;

    sub_flags #(.WIDTH(WIDTH)) u_sub_flags (
        .a    (a),
        .b    (b),
        .diff (diff),
        .n    (flags.n),
        .v    (flags.v),
        .z    (flags.z)
    );

    // Only the flags are consumed here; the difference itself is not needed.
    assign unused_diff = ^diff;

    assign eq = signed_lt(flags);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lt_q      <= 1'b0;
            same_q    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                lt_q   <= eq;
                same_q <= flags.z;
            end
        end
    end

endmodule

// File: tb/tb_less_than.sv
// Scoreboard bench for less_than: golden signed compare on eq, queued results for lt_q/same_q.
module tb_less_than;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         in_valid;
    logic         eq;
    logic         lt_q;
    logic         same_q;
    logic         out_valid;

    logic [1:0]   sb_q[$];
    logic         last_lt;
    logic         last_same;
    int           n_checks = 0;
    int           n_pass   = 0;

    logic [W-1:0] min_val;
    logic [W-1:0] max_val;

    less_than #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .eq        (eq),
        .lt_q      (lt_q),
        .same_q    (same_q),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic gold_lt(input logic [W-1:0] x, input logic [W-1:0] y);
        return $signed(x) < $signed(y);
    endfunction

    // One clock cycle: drive at negedge, check eq, then check the registered path after posedge.
    task automatic drive(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tv);
        logic       exp_valid;
        logic [1:0] exp_res;
        @(negedge clk);
        a        = ta;
        b        = tb;
        in_valid = tv;
        #1;
        chk("eq", eq, gold_lt(ta, tb));
        @(posedge clk);
        exp_valid = tv && rst_n;
        if (exp_valid) sb_q.push_back({gold_lt(ta, tb), ta == tb});
        #1;
        chk("out_valid", out_valid, exp_valid);
        if (out_valid) begin
            chk("sb_nonempty", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
                exp_res   = sb_q.pop_front();
                last_lt   = exp_res[1];
                last_same = exp_res[0];
            end
        end
        chk("lt_q", lt_q, last_lt);
        chk("same_q", same_q, last_same);
        chk("lt_same_excl", lt_q & same_q, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        min_val   = {1'b1, {(W-1){1'b0}}};
        max_val   = {1'b0, {(W-1){1'b1}}};
        last_lt   = 1'b0;
        last_same = 1'b0;
        a         = '0;
        b         = '0;
        in_valid  = 1'b0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #1;
        chk("rst_lt_q", lt_q, 0);
        chk("rst_same_q", same_q, 0);
        chk("rst_out_valid", out_valid, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        drive(1, 2, 1'b1);
        drive(2, 1, 1'b1);
        drive(-2, -1, 1'b1);
        drive(-1, -2, 1'b1);
        drive(0, 0, 1'b1);
        drive(-2, 1, 1'b1);
        drive(2, -1, 1'b1);
        drive(1, -2, 1'b1);
        drive(-1, 2, 1'b1);
        drive(min_val, max_val, 1'b1);
        drive(max_val, min_val, 1'b1);
        drive(min_val, min_val, 1'b1);
        drive(7, 3, 1'b0);
        drive(3, 7, 1'b0);
        drive(5, 5, 1'b1);
        chk("same5_same_q", same_q, 1);
        chk("same5_lt_q", lt_q, 0);
        chk("same5_out_valid", out_valid, 1);

        // Async reset between edges clears registered outputs at once; eq keeps tracking.
        #2 rst_n = 1'b0;
        #1;
        chk("arst_lt_q", lt_q, 0);
        chk("arst_same_q", same_q, 0);
        chk("arst_out_valid", out_valid, 0);
        a = 1;
        b = 2;
        #1;
        chk("eq_in_reset", eq, 1);
        sb_q.delete();
        last_lt   = 1'b0;
        last_same = 1'b0;
        drive(-5, 4, 1'b1);
        drive(4, 4, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(-8, 3, 1'b1);
        drive(9, 9, 1'b0);

        // Capture with lt_q = 1, then reset pre-empts the next pending capture.
        drive(-3, 3, 1'b1);
        @(negedge clk);
        a        = 6;
        b        = 6;
        in_valid = 1'b1;
        rst_n    = 1'b0;
        #1;
        chk("preempt_lt_q", lt_q, 0);
        @(posedge clk);
        #1;
        chk("preempt_out_valid", out_valid, 0);
        chk("preempt_same_q", same_q, 0);
        sb_q.delete();
        last_lt   = 1'b0;
        last_same = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10000; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = $urandom();
            rb = $urandom();
            case ($urandom_range(0, 7))
                0: rb = ra;
                1: ra = min_val;
                2: rb = max_val;
                3: rb = ra + 1;
                default: ;
            endcase
            drive(ra, rb, $urandom_range(0, 3) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/less_than.md
LESS_THAN -- requirements
Module: less_than

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; legal range 2..64.
REQ-002 clk  input  1  rising-edge clock for the registered path.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 a  input  WIDTH  operand A, two's-complement signed.
REQ-005 b  input  WIDTH  operand B, two's-complement signed.
REQ-006 in_valid  input  1  qualifies a/b for capture into the registered path.
REQ-007 eq  output  1  combinational result: 1 iff a < b (signed); the name is historical and does not mean equality.
REQ-008 lt_q  output  1  registered copy of the signed less-than result.
REQ-009 same_q  output  1  registered flag: 1 iff a == b.
REQ-010 out_valid  output  1  high for exactly one cycle when lt_q/same_q hold a newly captured result.

Function
REQ-011 eq SHALL be purely combinational from a and b: zero latency, no dependence on clk, rst_n or in_valid.
REQ-012 eq SHALL be computed as N xor V of the WIDTH-bit difference a - b, where N is the sign bit of the difference and V is signed overflow; a wrapped difference SHALL NOT be used alone.
REQ-013 eq SHALL be 0 when a == b.
REQ-014 Mixed signs SHALL be correct: a negative and b non-negative gives eq = 1; a non-negative and b negative gives eq = 0.
REQ-015 Extremes SHALL be correct with no overflow error: a = most-negative value and b = most-positive value gives eq = 1; the swapped pair gives eq = 0.
REQ-016 On a rising clk edge with in_valid = 1, lt_q SHALL load the current eq and same_q SHALL load (a == b); out_valid SHALL be 1 in the following cycle.
REQ-017 On a rising clk edge with in_valid = 0, lt_q and same_q SHALL hold their values and out_valid SHALL go to 0.
REQ-018 Back-to-back in_valid SHALL give one result per cycle with 1-cycle latency; there is no backpressure.
REQ-019 lt_q and same_q SHALL never both be 1.

Reset
REQ-020 When rst_n = 0, lt_q, same_q and out_valid SHALL go to 0 immediately, without waiting for clk.
REQ-021 Reset SHALL NOT affect eq, which keeps tracking a and b during reset.
REQ-022 Reset deassertion SHALL be synchronized to clk; the first capture occurs on the first rising edge with rst_n = 1 and in_valid = 1.
REQ-023 Reset asserted mid-stream SHALL discard any pending result; out_valid SHALL NOT pulse for a capture that reset pre-empted.

Structure
REQ-024 WIDTH default and any shared width constants SHALL live in the shared alu package.
REQ-025 The subtract-and-flag logic SHALL be one sub-module, sub_flags, built as a ripple-carry subtractor from full-adder cells: inputs a and b; outputs diff, n, v and z.
REQ-026 The top level SHALL derive eq = n ^ v and the equality flag from z, then register both.
REQ-027 No behavioral "<" on signed types SHALL be used in the datapath.

Verification
REQ-028 a=1, b=2 -> eq=1; a=2, b=1 -> eq=0.
REQ-029 a=-2, b=-1 -> eq=1; a=-1, b=-2 -> eq=0; a=0, b=0 -> eq=0.
REQ-030 a=-2, b=1 -> eq=1; a=2, b=-1 -> eq=0; a=1, b=-2 -> eq=0; a=-1, b=2 -> eq=1.
REQ-031 a=0x80000000, b=0x7FFFFFFF -> eq=1; swapped -> eq=0.
REQ-032 in_valid=1 with a=5, b=5, then one clk edge -> same_q=1, lt_q=0, out_valid=1 for one cycle; rst_n pulled low between edges -> all registered outputs 0 at once.
REQ-033 Random signed pairs over 10k cycles -> eq matches a golden signed compare, and lt_q/same_q match the golden compare delayed by one cycle.
